seq_divider: RTL

- Multi-cycle signed integer divider; the inverse counterpart of the team's sequential/Booth multipliers.
- Takes dividend A and divisor B and returns quotient Q and remainder R.
- Uses radix-2 restoring division on magnitudes, then applies a sign fix-up.
- Sits beside the multiplier in the arithmetic datapath with the same clk/rst/en style, plus a busy/done handshake.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 22 ++
 rtl/seq_divider.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_e;

    localparam int DIV_DEFAULT_WIDTH = 32;

    // Step counter width; it only has to reach WIDTH-1.
    function automatic int div_cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes (pure combinational).
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] p_o,
    output logic             q_o
);

    // The shifted partial remainder needs one extra bit; after a subtract it
    // is again below |B|, so the stored remainder fits in WIDTH bits.
    logic [WIDTH:0] shifted;

    assign shifted = {p_i, bit_i};
    assign q_o     = (shifted >= {1'b0, b_i});
    assign p_o     = q_o ? WIDTH'(shifted - {1'b0, b_i}) : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring division on magnitudes, then a sign
// fix-up cycle. C-style truncating semantics, busy/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int             CW   = div_cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] bmag_q, bmag_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dzo_q, dzo_d;

    logic [WIDTH-1:0] a_mag, b_mag, r_mag, step_p;
    logic             step_q;

    // -(-2^(WIDTH-1)) wraps to 2^(WIDTH-1), which is exact when read unsigned.
    assign a_mag = A[WIDTH-1] ? -A : A;
    assign b_mag = B[WIDTH-1] ? -B : B;

    // Divide-by-zero leaves |A| untouched in the dividend register, so R = A.
    assign r_mag = dz_q ? dvd_q : p_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i   (p_q),
        .b_i   (bmag_q),
        .bit_i (dvd_q[WIDTH-1]),
        .p_o   (step_p),
        .q_o   (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dzo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dzo_q   <= dzo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dzo_d   = dzo_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    dvd_d   = a_mag;
                    bmag_d  = b_mag;
                    p_d     = '0;
                    qneg_d  = A[WIDTH-1] ^ B[WIDTH-1];
                    rneg_d  = A[WIDTH-1];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    dz_d    = (B == '0);
                    state_d = (B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                // Quotient bits shift in from the bottom as dividend bits leave the top.
                p_d   = step_p;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST)
                    state_d = FIX;
            end
            FIX: begin
                quo_d   = dz_q ? '1 : (qneg_q ? -dvd_q : dvd_q);
                rem_d   = rneg_q ? -r_mag : r_mag;
                dzo_d   = dz_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Q           = quo_q;
    assign R           = rem_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dzo_q;

endmodule
